// File: rtl/param_stack_pkg.sv
// -----------------------------------------------------------------------------
// param_stack_pkg
// Shared definitions for the parametrised LIFO stack:
//   cw()  - width of the occupancy counter, able to hold 0..DEPTH
//   aw()  - width of a memory address, able to hold 0..DEPTH-1
//   op_e  - decode of the {push, pop} request pair
// -----------------------------------------------------------------------------
package param_stack_pkg;

    // Counter width: DEPTH itself must be representable, hence DEPTH+1.
    function automatic int cw(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Address width: at least one bit so a 1-entry corner never yields [-1:0].
    function automatic int aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Encoding is {push, pop} so the request pair casts straight onto it.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_REPL = 2'b11
    } op_e;

endpackage : param_stack_pkg

// File: rtl/param_stack_if.sv
// -----------------------------------------------------------------------------
// param_stack_if
// Producer/consumer bundle of the LIFO stack.
//   master : drives data_in, push, pop, flush, clr_err; observes status/data
//   slave  : the stack itself; the mirror image of master
// Signals:
//   data_in      word to push
//   push/pop     requests ({1,1} = replace top)
//   flush        empty the stack in one cycle
//   clr_err      clear sticky overflow/underflow
//   data_out     last popped word (registered), data_valid its strobe
//   top          combinational peek of top entry, 0 when empty
//   count        occupancy 0..DEPTH
//   full/empty/almost_full/almost_empty  decodes of count
//   overflow/underflow  sticky error flags
// -----------------------------------------------------------------------------
interface param_stack_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
);
    import param_stack_pkg::*;

    localparam int CW = cw(DEPTH);

    logic [WIDTH-1:0] data_in;
    logic             push;
    logic             pop;
    logic             flush;
    logic             clr_err;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic [WIDTH-1:0] top;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic             overflow;
    logic             underflow;

    modport master (
        output data_in, push, pop, flush, clr_err,
        input  data_out, data_valid, top, count, full, empty,
               almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  data_in, push, pop, flush, clr_err,
        output data_out, data_valid, top, count, full, empty,
               almost_full, almost_empty, overflow, underflow
    );

endinterface : param_stack_if

// File: rtl/param_stack_mem.sv
// -----------------------------------------------------------------------------
// stack_mem
// DEPTH x WIDTH register array backing the stack.
//   clk    rising-edge clock
//   we     write enable (synchronous)
//   waddr  write address, wdata write data
//   raddr  read address, rdata asynchronous read data
// Addresses at or above DEPTH (possible when DEPTH is not a power of two)
// write nothing and read back zero.
// -----------------------------------------------------------------------------
module stack_mem #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: storage arrays get no reset; only the occupancy count decides
    // which entries are meaningful, so clearing the array would be wasted logic.
    always_ff @(posedge clk) begin
        if (we && (int'(waddr) < DEPTH)) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = (int'(raddr) < DEPTH) ? mem_q[raddr] : '0;

endmodule : stack_mem

// File: rtl/param_stack.sv
// -----------------------------------------------------------------------------
// param_stack
// Parametrised LIFO with occupancy count, almost-full/almost-empty thresholds,
// combinational top-of-stack peek, registered pop output with valid strobe,
// sticky overflow/underflow flags and single-cycle flush.
//   clk  rising-edge clock
//   rst  synchronous active-high reset (discards all entries)
//   bus  param_stack_if.slave carrying data, requests and status
// Per-cycle priority: rst > flush > {push, pop}.
// -----------------------------------------------------------------------------
module param_stack
    import param_stack_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic          clk,
    input  logic          rst,
    param_stack_if.slave  bus
);

    localparam int CW = cw(DEPTH);
    localparam int AW = aw(DEPTH);

    // Out-of-range configuration stops elaboration.
    if (WIDTH < 1) begin : g_bad_width
        $error("param_stack: WIDTH must be >= 1");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("param_stack: DEPTH must be >= 2");
    end
    if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
        $error("param_stack: AF_LEVEL must be in 1..DEPTH");
    end
    if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_ae
        $error("param_stack: AE_LEVEL must be in 0..DEPTH-1");
    end

    // State
    logic [CW-1:0]    count_q,    count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             valid_q,    valid_d;
    logic             ovf_q,      ovf_d;
    logic             unf_q,      unf_d;

    // Memory port signals
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [AW-1:0]    top_addr;
    logic [AW-1:0]    push_addr;
    logic [WIDTH-1:0] rdata;

    logic             full;
    logic             empty;
    op_e              op;

    // Status decodes straight off the registered count.
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // The count itself is the stack pointer: next free slot is mem[count],
    // top entry is mem[count-1]. When empty the top address wraps to an
    // arbitrary value, but its read data is masked below.
    assign push_addr = AW'(count_q);
    assign top_addr  = AW'(count_q - CW'(1));

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (we & ~rst),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (top_addr),
        .rdata (rdata)
    );

    assign op = op_e'({bus.push, bus.pop});

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        count_d    = count_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        // Clear first; an error raised below in the same cycle overrides it.
        ovf_d      = ovf_q & ~bus.clr_err;
        unf_d      = unf_q & ~bus.clr_err;
        we         = 1'b0;
        waddr      = push_addr;
        wdata      = bus.data_in;

        if (bus.flush) begin
            count_d = '0;
        end else begin
            case (op)
                OP_NONE: ;
                OP_PUSH: begin
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        we      = 1'b1;
                        count_d = count_q + CW'(1);
                    end
                end
                OP_POP: begin
                    if (empty) begin
                        unf_d = 1'b1;
                    end else begin
                        data_out_d = rdata;
                        valid_d    = 1'b1;
                        count_d    = count_q - CW'(1);
                    end
                end
                OP_REPL: begin
                    if (empty) begin
                        // Nothing to pop: behaves as a plain push into slot 0.
                        we      = 1'b1;
                        count_d = CW'(1);
                    end else begin
                        // Swap top: old value out, new value in, count kept.
                        data_out_d = rdata;
                        valid_d    = 1'b1;
                        we         = 1'b1;
                        waddr      = top_addr;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign bus.count        = count_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
    assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
    assign bus.top          = empty ? '0 : rdata;
    assign bus.data_out     = data_out_q;
    assign bus.data_valid   = valid_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

endmodule : param_stack

// File: tb/tb_param_stack.sv
// -----------------------------------------------------------------------------
// tb_param_stack
// Directed bench for param_stack: a default 4x8 instance driven from a vector
// table, plus a 16x5 instance (AF_LEVEL=4, AE_LEVEL=2) exercised by a
// hand-written fill/drain sequence.
// -----------------------------------------------------------------------------
module tb_param_stack;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst5 = 1'b1;

    always #5 clk = ~clk;

    param_stack_if #(.WIDTH(4),  .DEPTH(8)) bus  ();
    param_stack_if #(.WIDTH(16), .DEPTH(5)) bus5 ();

    param_stack #(.WIDTH(4), .DEPTH(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    param_stack #(.WIDTH(16), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(2)) u_dut5 (
        .clk (clk),
        .rst (rst5),
        .bus (bus5)
    );

    typedef struct {
        string    name;
        bit       rst;
        bit       flush;
        bit       push;
        bit       pop;
        bit       clr_err;
        bit [3:0] din;
        int       cnt;
        bit [3:0] top;
        bit [3:0] dout;
        bit       valid;
        bit       ovf;
        bit       unf;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input bit r, input bit f, input bit pu, input bit po,
                       input bit ce, input int din, input int cnt, input int top,
                       input int dout, input bit valid, input bit ovf, input bit unf);
        vec_t v;
        v.name = name; v.rst = r; v.flush = f; v.push = pu; v.pop = po; v.clr_err = ce;
        v.din = 4'(din); v.cnt = cnt; v.top = 4'(top); v.dout = 4'(dout);
        v.valid = valid; v.ovf = ovf; v.unf = unf;
        vecs.push_back(v);
    endtask

    task automatic apply(input int idx, input vec_t v);
        string tag;
        rst         = v.rst;
        bus.flush   = v.flush;
        bus.push    = v.push;
        bus.pop     = v.pop;
        bus.clr_err = v.clr_err;
        bus.data_in = v.din;
        @(posedge clk);
        #1;
        tag = $sformatf("v%0d_%s", idx, v.name);
        check({tag, ".count"},        32'(bus.count),        32'(v.cnt));
        check({tag, ".top"},          32'(bus.top),          32'(v.top));
        check({tag, ".data_out"},     32'(bus.data_out),     32'(v.dout));
        check({tag, ".data_valid"},   32'(bus.data_valid),   32'(v.valid));
        check({tag, ".overflow"},     32'(bus.overflow),     32'(v.ovf));
        check({tag, ".underflow"},    32'(bus.underflow),    32'(v.unf));
        check({tag, ".full"},         32'(bus.full),         32'(v.cnt == 8));
        check({tag, ".empty"},        32'(bus.empty),        32'(v.cnt == 0));
        check({tag, ".almost_full"},  32'(bus.almost_full),  32'(v.cnt >= 7));
        check({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(v.cnt <= 1));
    endtask

    task automatic step5(input bit r, input bit pu, input bit po, input logic [15:0] din);
        rst5         = r;
        bus5.push    = pu;
        bus5.pop     = po;
        bus5.data_in = din;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.flush = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.clr_err = 1'b0; bus.data_in = '0;
        bus5.flush = 1'b0; bus5.push = 1'b0; bus5.pop = 1'b0; bus5.clr_err = 1'b0; bus5.data_in = '0;

        //   name            rst fl pu po ce din  cnt top dout v ovf unf
        add("reset",          1, 0, 0, 0, 0, 0,    0,  0,  0,  0, 0, 0);
        for (int k = 1; k <= 8; k++)
            add("fill",       0, 0, 1, 0, 0, k,    k,  k,  0,  0, 0, 0);
        add("push_full",      0, 0, 1, 0, 0, 15,   8,  8,  0,  0, 1, 0);
        add("ovf_sticky",     0, 0, 0, 0, 0, 0,    8,  8,  0,  0, 1, 0);
        add("clr_ovf",        0, 0, 0, 0, 1, 0,    8,  8,  0,  0, 0, 0);
        for (int j = 1; j <= 8; j++)
            add("drain",      0, 0, 0, 1, 0, 0,  8-j, 8-j, 9-j, 1, 0, 0);
        add("pop_empty",      0, 0, 0, 1, 0, 0,    0,  0,  1,  0, 0, 1);
        add("clr_vs_set",     0, 0, 0, 1, 1, 0,    0,  0,  1,  0, 0, 1);
        add("clr_unf",        0, 0, 0, 0, 1, 0,    0,  0,  1,  0, 0, 0);
        add("push3",          0, 0, 1, 0, 0, 3,    1,  3,  1,  0, 0, 0);
        add("push5",          0, 0, 1, 0, 0, 5,    2,  5,  1,  0, 0, 0);
        add("replace",        0, 0, 1, 1, 0, 9,    2,  9,  5,  1, 0, 0);
        add("valid_drops",    0, 0, 0, 0, 0, 0,    2,  9,  5,  0, 0, 0);
        add("pop9",           0, 0, 0, 1, 0, 0,    1,  3,  9,  1, 0, 0);
        add("pop3",           0, 0, 0, 1, 0, 0,    0,  0,  3,  1, 0, 0);
        add("repl_empty",     0, 0, 1, 1, 0, 6,    1,  6,  3,  0, 0, 0);
        add("push7",          0, 0, 1, 0, 0, 7,    2,  7,  3,  0, 0, 0);
        add("push8",          0, 0, 1, 0, 0, 8,    3,  8,  3,  0, 0, 0);
        add("pop8",           0, 0, 0, 1, 0, 0,    2,  7,  8,  1, 0, 0);
        add("flush_push",     0, 1, 1, 0, 0, 10,   0,  0,  8,  0, 0, 0);
        add("flush_pop",      0, 1, 0, 1, 0, 0,    0,  0,  8,  0, 0, 0);
        add("pop_empty2",     0, 0, 0, 1, 0, 0,    0,  0,  8,  0, 0, 1);
        add("push1",          0, 0, 1, 0, 0, 1,    1,  1,  8,  0, 0, 1);
        add("push2",          0, 0, 1, 0, 0, 2,    2,  2,  8,  0, 0, 1);
        add("push3b",         0, 0, 1, 0, 0, 3,    3,  3,  8,  0, 0, 1);
        add("rst_mid",        1, 0, 1, 0, 0, 4,    0,  0,  0,  0, 0, 0);
        for (int k = 1; k <= 8; k++)
            add("refill",     0, 0, 1, 0, 0, k+2,  k, k+2, 0,  0, 0, 0);
        add("repl_full",      0, 0, 1, 1, 0, 12,   8, 12, 10,  1, 0, 0);
        add("flush_full",     0, 1, 0, 0, 0, 0,    0,  0, 10,  0, 0, 0);

        @(negedge clk);
        foreach (vecs[i]) apply(i, vecs[i]);
        rst = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.flush = 1'b0; bus.clr_err = 1'b0;

        // 16x5 instance with AF_LEVEL=4, AE_LEVEL=2: fill, overflow, drain.
        step5(1'b1, 1'b0, 1'b0, 16'h0);
        check("d5_reset.count",        32'(bus5.count),        32'd0);
        check("d5_reset.almost_empty", 32'(bus5.almost_empty), 32'd1);
        check("d5_reset.almost_full",  32'(bus5.almost_full),  32'd0);
        for (int k = 1; k <= 5; k++) begin
            step5(1'b0, 1'b1, 1'b0, 16'hA000 + 16'(k));
            check($sformatf("d5_fill%0d.count", k),        32'(bus5.count),        32'(k));
            check($sformatf("d5_fill%0d.top", k),          32'(bus5.top),          32'h0000A000 + 32'(k));
            check($sformatf("d5_fill%0d.almost_empty", k), 32'(bus5.almost_empty), 32'(k <= 2));
            check($sformatf("d5_fill%0d.almost_full", k),  32'(bus5.almost_full),  32'(k >= 4));
            check($sformatf("d5_fill%0d.full", k),         32'(bus5.full),         32'(k == 5));
        end
        step5(1'b0, 1'b1, 1'b0, 16'hBEEF);
        check("d5_ovf.overflow", 32'(bus5.overflow), 32'd1);
        check("d5_ovf.count",    32'(bus5.count),    32'd5);
        check("d5_ovf.top",      32'(bus5.top),      32'h0000A005);
        for (int j = 1; j <= 5; j++) begin
            step5(1'b0, 1'b0, 1'b1, 16'h0);
            check($sformatf("d5_drain%0d.count", j),        32'(bus5.count),        32'(5 - j));
            check($sformatf("d5_drain%0d.data_out", j),     32'(bus5.data_out),     32'h0000A000 + 32'(6 - j));
            check($sformatf("d5_drain%0d.data_valid", j),   32'(bus5.data_valid),   32'd1);
            check($sformatf("d5_drain%0d.almost_empty", j), 32'(bus5.almost_empty), 32'((5 - j) <= 2));
            check($sformatf("d5_drain%0d.almost_full", j),  32'(bus5.almost_full),  32'((5 - j) >= 4));
            check($sformatf("d5_drain%0d.full", j),         32'(bus5.full),         32'd0);
        end
        step5(1'b0, 1'b0, 1'b0, 16'h0);
        check("d5_idle.data_valid", 32'(bus5.data_valid), 32'd0);
        check("d5_idle.top",        32'(bus5.top),        32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_param_stack
